core_wb_s: RTL and testbench
============================

CORE_WB_S -- requirements
Module: core_wb_s

Interface
REQ-001 SHALL take parameter TIMEOUT, default 255: number of consecutive l1d wait cycles after which timeout is flagged.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port wb_val_inst_in, input, 1: instruction from mem stage is valid.
REQ-005 SHALL have port wb_alu_result_in, input, 32: ALU result / load address.
REQ-006 SHALL have port wb_pc_4_in, input, 32: PC+4 of the instruction.
REQ-007 SHALL have port wb_mux_alu_mem_in, input, 1: 1 = load (memory source), 0 = ALU source.
REQ-008 SHALL have port wb_we_reg_file_in, input, 1: instruction writes the register file.
REQ-009 SHALL have port wb_wb_sx_op_in, input, 3: load extract/extend opcode.
REQ-010 SHALL have port wb_rd_in, input, 5: destination register.
REQ-011 SHALL have port l1d_ack_in, input, 1: L1D response valid.
REQ-012 SHALL have port l1d_rd_data_in, input, 32: L1D read word.
REQ-013 SHALL have port wb_stall_out, output, 1: holds upstream stages (drives mem_enb low).
REQ-014 SHALL have ports wb_rf_we_out (1), wb_rf_rd_out (5) and wb_rf_data_out (32), all outputs: registered register-file write port.
REQ-015 SHALL have port wb2mem_bp_data_out, output, 32: bypass data, equal to wb_rf_data_out.
REQ-016 SHALL have ports wb2haz_we_out (1) and wb2haz_rd_out (5), outputs: equal to wb_rf_we_out and wb_rf_rd_out.
REQ-017 SHALL have ports wb_retire_out (1) and wb_retire_pc_out (32), outputs: registered retire strobe and PC of the retired instruction.
REQ-018 SHALL have port wb_instret_out, output, 32: retired-instruction counter.
REQ-019 SHALL have port wb_l1d_timeout_out, output, 1: sticky L1D timeout flag.

Function
REQ-020 SHALL implement FSM with states IDLE and WAIT_ACK.
REQ-021 Load SHALL be defined as wb_val_inst_in & wb_mux_alu_mem_in. Completion SHALL be defined as (valid & !load) | (load & l1d_ack_in).
REQ-022 IDLE->WAIT_ACK on load & !ack. WAIT_ACK->IDLE on ack. All other cases hold state.
REQ-023 wb_stall_out SHALL be combinational, = load & !l1d_ack_in, in either state. Upstream holds inputs stable while stalled.
REQ-024 l1d_ack_in SHALL be ignored when no load is present, with no state or output change. Ack in the same cycle as the load SHALL complete with zero wait.
REQ-025 Extraction SHALL use addr = wb_alu_result_in[1:0] as byte offset, and half select = addr[1].
REQ-026 sx_op encodings: 000 word; 001 byte sign-extended; 010 half sign-extended; 011 byte zero-extended; 100 half zero-extended; 101-111 treated as word.
REQ-027 Write data SHALL be the extracted load data when wb_mux_alu_mem_in=1, and wb_alu_result_in otherwise.
REQ-028 On the completion edge, the stage SHALL register: wb_rf_we_out = wb_we_reg_file_in & (rd != 0); wb_rf_rd_out = rd; wb_rf_data_out = data; wb_retire_out = 1; wb_retire_pc_out = wb_pc_4_in - 4 (mod 2^32).
REQ-029 Without completion, wb_rf_we_out and wb_retire_out SHALL be 0 next cycle, and the rd, data and PC registers SHALL hold. Latency is 1 cycle from completion to outputs.
REQ-030 wb_instret_out SHALL increment by 1 on each completion and wrap 0xFFFFFFFF->0.
REQ-031 The wait counter (8 bits minimum) SHALL clear in IDLE and increment each WAIT_ACK cycle without ack, saturating.
REQ-032 When the wait counter reaches TIMEOUT, wb_l1d_timeout_out SHALL set and remain set until reset. The FSM SHALL keep waiting.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE; wait counter 0; wb_rf_we_out, wb_retire_out and wb_l1d_timeout_out 0; wb_rf_rd_out 0; wb_rf_data_out, wb_retire_pc_out and wb_instret_out 0x00000000.
REQ-034 During reset, wb_stall_out SHALL remain combinational per REQ-023.
REQ-035 Reset asserted during WAIT_ACK SHALL abandon the load with no register-file write. An ack arriving after release with no load present SHALL be ignored.

Verification
REQ-036 ALU op: valid=1, mux=0, we=1, rd=5, alu=0x12345678, pc_4=0x104 -> next cycle rf_we=1, rd=5, data=0x12345678, retire_pc=0x100, instret=1, stall never asserted.
REQ-037 Load byte signed: mux=1, sx_op=001, addr=...2, ack same cycle, rd_data=0x0080FF00 -> data=0xFFFFFF80, no stall.
REQ-038 Load half unsigned with 3-cycle ack delay: addr=...2, sx_op=100, rd_data=0xBEEF0000 -> stall=1 for 3 cycles, then data=0x0000BEEF one cycle after ack, single retire.
REQ-039 rd=0 with we=1, alu=0xFFFFFFFF -> rf_we=0, retire=1, instret increments.
REQ-040 TIMEOUT=4, load with no ack for 6 cycles, then ack -> timeout set at wait count 4 and stays set. Then completion writes normally.
REQ-041 rst_n pulsed low mid WAIT_ACK, ack after release -> all outputs at reset values, no write, instret=0.

Source files
------------

// File: rtl/core_wb_s_if.sv
// rtl/core_wb_s_if.sv - write-back stage bus: mem-stage inputs, L1D response, RF/retire outputs
interface core_wb_s_if;
   logic        wb_val_inst_in;
   logic [31:0] wb_alu_result_in;
   logic [31:0] wb_pc_4_in;
   logic        wb_mux_alu_mem_in;
   logic        wb_we_reg_file_in;
   logic [2:0]  wb_wb_sx_op_in;
   logic [4:0]  wb_rd_in;
   logic        l1d_ack_in;
   logic [31:0] l1d_rd_data_in;

   logic        wb_stall_out;
   logic        wb_rf_we_out;
   logic [4:0]  wb_rf_rd_out;
   logic [31:0] wb_rf_data_out;
   logic [31:0] wb2mem_bp_data_out;
   logic        wb2haz_we_out;
   logic [4:0]  wb2haz_rd_out;
   logic        wb_retire_out;
   logic [31:0] wb_retire_pc_out;
   logic [31:0] wb_instret_out;
   logic        wb_l1d_timeout_out;

   modport slave (
      input  wb_val_inst_in, wb_alu_result_in, wb_pc_4_in, wb_mux_alu_mem_in,
             wb_we_reg_file_in, wb_wb_sx_op_in, wb_rd_in, l1d_ack_in, l1d_rd_data_in,
      output wb_stall_out, wb_rf_we_out, wb_rf_rd_out, wb_rf_data_out,
             wb2mem_bp_data_out, wb2haz_we_out, wb2haz_rd_out, wb_retire_out,
             wb_retire_pc_out, wb_instret_out, wb_l1d_timeout_out
   );

   modport master (
      output wb_val_inst_in, wb_alu_result_in, wb_pc_4_in, wb_mux_alu_mem_in,
             wb_we_reg_file_in, wb_wb_sx_op_in, wb_rd_in, l1d_ack_in, l1d_rd_data_in,
      input  wb_stall_out, wb_rf_we_out, wb_rf_rd_out, wb_rf_data_out,
             wb2mem_bp_data_out, wb2haz_we_out, wb2haz_rd_out, wb_retire_out,
             wb_retire_pc_out, wb_instret_out, wb_l1d_timeout_out
   );
endinterface

// File: rtl/core_wb_s.sv
// rtl/core_wb_s.sv - write-back stage: load extract/extend, L1D ack wait FSM, RF write and retire
module core_wb_s #(
   parameter int TIMEOUT = 255
) (
   input logic        clk,
   input logic        rst_n,
   core_wb_s_if.slave bus
);
   localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          timeout_hit;

   logic          load, done;
   logic [1:0]    addr;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   ld_data, wr_data;

   logic          rf_we, retire, l1d_timeout;
   logic [4:0]    rf_rd;
   logic [31:0]   rf_data, retire_pc, instret;

   assign load = bus.wb_val_inst_in & bus.wb_mux_alu_mem_in;
   assign done = (bus.wb_val_inst_in & ~bus.wb_mux_alu_mem_in) | (load & bus.l1d_ack_in);
   assign addr = bus.wb_alu_result_in[1:0];

   // Stall is purely combinational so it also holds upstream while reset is asserted
   assign bus.wb_stall_out = load & ~bus.l1d_ack_in;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_hit  = 1'b0;
      case (state)
         IDLE: begin
            wait_cnt_nxt = '0;
            if (load && !bus.l1d_ack_in) begin
               state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (load && bus.l1d_ack_in) begin
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end else begin
               if (wait_cnt != '1) begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end
               timeout_hit = (wait_cnt_nxt >= TO_LIM);
            end
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         l1d_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_hit) begin
            l1d_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      sel_byte = 8'h00;
      case (addr)
         2'd0: sel_byte = bus.l1d_rd_data_in[7:0];
         2'd1: sel_byte = bus.l1d_rd_data_in[15:8];
         2'd2: sel_byte = bus.l1d_rd_data_in[23:16];
         2'd3: sel_byte = bus.l1d_rd_data_in[31:24];
         default: sel_byte = 8'h00;
      endcase
      sel_half = addr[1] ? bus.l1d_rd_data_in[31:16] : bus.l1d_rd_data_in[15:0];
      case (bus.wb_wb_sx_op_in)
         3'b001:  ld_data = {{24{sel_byte[7]}}, sel_byte};
         3'b010:  ld_data = {{16{sel_half[15]}}, sel_half};
         3'b011:  ld_data = {24'h000000, sel_byte};
         3'b100:  ld_data = {16'h0000, sel_half};
         default: ld_data = bus.l1d_rd_data_in;
      endcase
      wr_data = bus.wb_mux_alu_mem_in ? ld_data : bus.wb_alu_result_in;
   end

   // Strobes drop when nothing completes; rd/data/pc keep the last retired values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we     <= 1'b0;
         rf_rd     <= 5'd0;
         rf_data   <= 32'h0000_0000;
         retire    <= 1'b0;
         retire_pc <= 32'h0000_0000;
         instret   <= 32'h0000_0000;
      end else if (done) begin
         rf_we     <= bus.wb_we_reg_file_in & (bus.wb_rd_in != 5'd0);
         rf_rd     <= bus.wb_rd_in;
         rf_data   <= wr_data;
         retire    <= 1'b1;
         retire_pc <= bus.wb_pc_4_in - 32'd4;
         instret   <= instret + 32'd1;
      end else begin
         rf_we  <= 1'b0;
         retire <= 1'b0;
      end
   end

   assign bus.wb_rf_we_out       = rf_we;
   assign bus.wb_rf_rd_out       = rf_rd;
   assign bus.wb_rf_data_out     = rf_data;
   assign bus.wb2mem_bp_data_out = rf_data;
   assign bus.wb2haz_we_out      = rf_we;
   assign bus.wb2haz_rd_out      = rf_rd;
   assign bus.wb_retire_out      = retire;
   assign bus.wb_retire_pc_out   = retire_pc;
   assign bus.wb_instret_out     = instret;
   assign bus.wb_l1d_timeout_out = l1d_timeout;
endmodule

// File: tb/tb_core_wb_s.sv
// tb/tb_core_wb_s.sv - directed and randomized checks of core_wb_s against a behavioural model
module tb_core_wb_s;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_wb_s_if bus ();
   core_wb_s #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   logic        m_we, m_ret, m_to;
   logic [4:0]  m_rd;
   logic [31:0] m_data, m_pc, m_instret;
   int          m_run;

   function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] off, logic [2:0] op);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'h0000_00FF;
      h = (w >> (16 * off[1])) & 32'h0000_FFFF;
      case (op)
         3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd3:    return b;
         3'd4:    return h;
         default: return w;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_we = 1'b0; m_ret = 1'b0; m_to = 1'b0; m_rd = 5'd0;
      m_data = 32'd0; m_pc = 32'd0; m_instret = 32'd0; m_run = 0;
   endtask

   task automatic drive(logic v, logic [31:0] alu, logic [31:0] pc4, logic mux, logic we,
                        logic [2:0] sx, logic [4:0] rd, logic ack, logic [31:0] rdat);
      bus.wb_val_inst_in    = v;
      bus.wb_alu_result_in  = alu;
      bus.wb_pc_4_in        = pc4;
      bus.wb_mux_alu_mem_in = mux;
      bus.wb_we_reg_file_in = we;
      bus.wb_wb_sx_op_in    = sx;
      bus.wb_rd_in          = rd;
      bus.l1d_ack_in        = ack;
      bus.l1d_rd_data_in    = rdat;
   endtask

   task automatic check_outputs();
      chk("rf_we", 32'(bus.wb_rf_we_out), 32'(m_we));
      chk("rf_rd", 32'(bus.wb_rf_rd_out), 32'(m_rd));
      chk("rf_data", bus.wb_rf_data_out, m_data);
      chk("bp_data", bus.wb2mem_bp_data_out, m_data);
      chk("haz_we", 32'(bus.wb2haz_we_out), 32'(m_we));
      chk("haz_rd", 32'(bus.wb2haz_rd_out), 32'(m_rd));
      chk("retire", 32'(bus.wb_retire_out), 32'(m_ret));
      chk("retire_pc", bus.wb_retire_pc_out, m_pc);
      chk("instret", bus.wb_instret_out, m_instret);
      chk("timeout", 32'(bus.wb_l1d_timeout_out), 32'(m_to));
   endtask

   // One clock: check stall on the applied inputs, advance the model, check registered outputs
   task automatic cycle();
      logic ld, comp;
      #1;
      ld   = bus.wb_val_inst_in & bus.wb_mux_alu_mem_in;
      comp = (bus.wb_val_inst_in & !bus.wb_mux_alu_mem_in) | (ld & bus.l1d_ack_in);
      chk("stall", 32'(bus.wb_stall_out), 32'(ld & !bus.l1d_ack_in));
      if (comp) begin
         m_we      = bus.wb_we_reg_file_in && (bus.wb_rd_in != 5'd0);
         m_rd      = bus.wb_rd_in;
         m_data    = bus.wb_mux_alu_mem_in
                     ? extract(bus.l1d_rd_data_in, bus.wb_alu_result_in[1:0], bus.wb_wb_sx_op_in)
                     : bus.wb_alu_result_in;
         m_ret     = 1'b1;
         m_pc      = bus.wb_pc_4_in - 32'd4;
         m_instret = m_instret + 32'd1;
         m_run     = 0;
      end else begin
         m_we  = 1'b0;
         m_ret = 1'b0;
         if (ld) begin
            m_run++;
            if (m_run > TO) m_to = 1'b1;
         end else begin
            m_run = 0;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [31:0] ralu, rdat, rpc;
      logic        rv, rmux;
      int          dly;

      model_reset();
      drive(1'b1, 32'h0, 32'h4, 1'b1, 1'b1, 3'd0, 5'd1, 1'b0, 32'h0);
      #12;
      check_outputs();
      chk("stall_in_reset", 32'(bus.wb_stall_out), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      drive(1'b1, 32'h1234_5678, 32'h104, 1'b0, 1'b1, 3'd0, 5'd5, 1'b0, 32'h0);
      cycle();
      chk("alu_data", bus.wb_rf_data_out, 32'h1234_5678);
      chk("alu_pc", bus.wb_retire_pc_out, 32'h100);
      chk("alu_instret", bus.wb_instret_out, 32'd1);

      drive(1'b1, 32'h1002, 32'h208, 1'b1, 1'b1, 3'b001, 5'd7, 1'b1, 32'h0080_FF00);
      cycle();
      chk("lb_data", bus.wb_rf_data_out, 32'hFFFF_FF80);

      drive(1'b1, 32'h2002, 32'h30C, 1'b1, 1'b1, 3'b100, 5'd9, 1'b0, 32'hBEEF_0000);
      repeat (3) cycle();
      chk("lhu_no_retire", 32'(bus.wb_retire_out), 32'd0);
      bus.l1d_ack_in = 1'b1;
      cycle();
      chk("lhu_data", bus.wb_rf_data_out, 32'h0000_BEEF);
      chk("lhu_instret", bus.wb_instret_out, 32'd3);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 32'h0);
      cycle();

      drive(1'b1, 32'hFFFF_FFFF, 32'h400, 1'b0, 1'b1, 3'd0, 5'd0, 1'b0, 32'h0);
      cycle();
      chk("rd0_we", 32'(bus.wb_rf_we_out), 32'd0);
      chk("rd0_retire", 32'(bus.wb_retire_out), 32'd1);

      for (int n = 0; n < 250; n++) begin
         rv   = ($urandom_range(0, 4) != 0);
         rmux = $urandom_range(0, 1) == 1;
         ralu = $urandom;
         rdat = $urandom;
         rpc  = $urandom;
         drive(rv, ralu, rpc, rmux, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), rdat);
         if (rv && rmux) begin
            dly = $urandom_range(0, 3);
            bus.l1d_ack_in = (dly == 0);
            for (int k = 0; k < dly; k++) cycle();
            bus.l1d_ack_in = 1'b1;
         end
         cycle();
      end

      drive(1'b1, 32'h10, 32'h504, 1'b1, 1'b1, 3'd0, 5'd3, 1'b0, 32'hCAFE_F00D);
      repeat (4) cycle();
      chk("timeout_early", 32'(bus.wb_l1d_timeout_out), 32'd0);
      repeat (2) cycle();
      chk("timeout_set", 32'(bus.wb_l1d_timeout_out), 32'd1);
      bus.l1d_ack_in = 1'b1;
      cycle();
      chk("timeout_ld_data", bus.wb_rf_data_out, 32'hCAFE_F00D);
      chk("timeout_ld_we", 32'(bus.wb_rf_we_out), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 32'h0);
      cycle();
      chk("timeout_sticky", 32'(bus.wb_l1d_timeout_out), 32'd1);

      drive(1'b1, 32'h20, 32'h604, 1'b1, 1'b1, 3'd0, 5'd4, 1'b0, 32'h1111_2222);
      repeat (2) cycle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("stall_reset_wait", 32'(bus.wb_stall_out), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 3'd0, 5'd4, 1'b1, 32'h3333_4444);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) cycle();
      chk("post_reset_instret", bus.wb_instret_out, 32'd0);
      drive(1'b1, 32'h55AA_55AA, 32'h708, 1'b0, 1'b1, 3'd0, 5'd8, 1'b0, 32'h0);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
